// File: rtl/vector_alu_seq.sv
// vector_alu_seq: N_LANES signed integer lanes with a start/busy/done handshake and a radix-2 iterative MUL.
// Build macro VALU_SATURATE_EN clamps overflowing ADD/SUB/MUL lanes instead of wrapping them.
module vector_alu_seq #(
    parameter int N_LANES = 4,
    parameter int LANE_W  = 32
) (
    input  logic                        clk,
    input  logic                        i_rst,
    input  logic                        iCE,
    input  logic                        i_operand_sel,
    input  logic [N_LANES*LANE_W-1:0]   operand,
    input  logic [3:0]                  Operation,
    input  logic                        i_start,
    output logic [N_LANES*LANE_W-1:0]   ALU_Output,
    output logic [N_LANES-1:0]          Overflow,
    output logic [N_LANES-1:0]          Underflow,
    output logic [N_LANES-1:0]          Exception,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int SH_W = $clog2(LANE_W);
    localparam int VW   = N_LANES * LANE_W;
    localparam int AW   = 2 * LANE_W;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MIN  = 4'd6;
    localparam logic [3:0] OP_MAX  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_PASS = 4'd10;

    localparam logic [LANE_W-1:0] S_MAX     = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] S_MIN     = {1'b1, {(LANE_W-1){1'b0}}};
    localparam logic [AW-1:0]     P_MAX     = {{(LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
    localparam logic [AW-1:0]     P_MIN_MAG = {{LANE_W{1'b0}}, S_MIN};
    localparam logic [SH_W-1:0]   CNT_LAST  = {SH_W{1'b1}};
    localparam logic [SH_W-1:0]   CNT_ONE   = {{(SH_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [LANE_W-1:0] res;
        logic              ovf;
        logic              unf;
        logic              exc;
    } lane_out_t;

    state_t              state_q, state_d;
    logic [VW-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]          op_q, op_d;
    logic [SH_W-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]       acc_q [N_LANES];
    logic [AW-1:0]       acc_d [N_LANES];
    logic [N_LANES-1:0]  ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [AW-1:0]       acc_nxt_s [N_LANES];
    lane_out_t           lane_o_s  [N_LANES];

    function automatic logic [LANE_W-1:0] magnitude(input logic [LANE_W-1:0] v);
        return v[LANE_W-1] ? -v : v;
    endfunction

    // One shift-add step: adds |a| << bit_idx when bit bit_idx of |b| is set.
    function automatic logic [AW-1:0] mul_step(input logic [LANE_W-1:0] a,
                                               input logic [LANE_W-1:0] b,
                                               input logic [AW-1:0]     acc,
                                               input logic [SH_W-1:0]   bit_idx);
        logic [LANE_W-1:0] b_mag;
        logic [AW-1:0]     addend;
        b_mag  = magnitude(b);
        addend = {{LANE_W{1'b0}}, magnitude(a)} << bit_idx;
        if (b_mag[bit_idx]) begin
            return acc + addend;
        end else begin
            return acc;
        end
    endfunction

    function automatic lane_out_t lane_alu(input logic [3:0]        op,
                                           input logic [LANE_W-1:0] a,
                                           input logic [LANE_W-1:0] b,
                                           input logic [AW-1:0]     prod_mag);
        lane_out_t                o;
        logic [LANE_W:0]          wide;
        logic [LANE_W-1:0]        prod_lo;
        logic signed [LANE_W-1:0] sra_v;
        logic                     prod_neg;
        logic                     big;
        logic [SH_W-1:0]          sh;
        o        = '0;
        wide     = '0;
        prod_neg = a[LANE_W-1] ^ b[LANE_W-1];
        prod_lo  = prod_neg ? -prod_mag[LANE_W-1:0] : prod_mag[LANE_W-1:0];
        sh       = b[SH_W-1:0];
        big      = |b[LANE_W-1:SH_W];
        sra_v    = $signed(a) >>> sh;
        case (op)
            OP_ADD: begin
                wide  = {a[LANE_W-1], a} + {b[LANE_W-1], b};
                o.res = wide[LANE_W-1:0];
                o.ovf = (wide[LANE_W:LANE_W-1] == 2'b01);
                o.unf = (wide[LANE_W:LANE_W-1] == 2'b10);
            end
            OP_SUB: begin
                wide  = {a[LANE_W-1], a} - {b[LANE_W-1], b};
                o.res = wide[LANE_W-1:0];
                o.ovf = (wide[LANE_W:LANE_W-1] == 2'b01);
                o.unf = (wide[LANE_W:LANE_W-1] == 2'b10);
            end
            OP_MUL: begin
                o.res = prod_lo;
                o.ovf = !prod_neg && (prod_mag > P_MAX);
                o.unf = prod_neg && (prod_mag > P_MIN_MAG);
            end
            OP_AND:  o.res = a & b;
            OP_OR:   o.res = a | b;
            OP_XOR:  o.res = a ^ b;
            OP_MIN:  o.res = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  o.res = ($signed(a) > $signed(b)) ? a : b;
            OP_SLL: begin
                o.exc = big;
                o.res = big ? {LANE_W{1'b0}} : (a << sh);
            end
            OP_SRA: begin
                o.exc = big;
                o.res = big ? {LANE_W{a[LANE_W-1]}} : sra_v;
            end
            OP_PASS: o.res = a;
            default: begin
                o.exc = 1'b1;
                o.res = '0;
            end
        endcase
`ifdef VALU_SATURATE_EN
        if (o.ovf) begin
            o.res = S_MAX;
        end else if (o.unf) begin
            o.res = S_MIN;
        end else begin
            o.res = o.res;
        end
`endif
        return o;
    endfunction

    // Per-lane datapath: next multiply accumulator and the lane result for the latched opcode.
    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            acc_nxt_s[i] = mul_step(a_q[i*LANE_W +: LANE_W], b_q[i*LANE_W +: LANE_W], acc_q[i], cnt_q);
            lane_o_s[i]  = lane_alu(op_q, a_q[i*LANE_W +: LANE_W], b_q[i*LANE_W +: LANE_W], acc_nxt_s[i]);
        end
    end

    // FSM next-state, operand loading and result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        exc_d   = exc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_EXEC;
                    op_d    = Operation;
                    cnt_d   = '0;
                    acc_d   = '{default: '0};
                    busy_d  = 1'b1;
                end else if (i_operand_sel) begin
                    b_d = operand;
                end else begin
                    a_d = operand;
                end
            end
            ST_EXEC: begin
                // MUL iterates until the last bit of |B| has been folded in.
                if ((op_q == OP_MUL) && (cnt_q != CNT_LAST)) begin
                    cnt_d = cnt_q + CNT_ONE;
                    acc_d = acc_nxt_s;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    for (int i = 0; i < N_LANES; i++) begin
                        res_d[i*LANE_W +: LANE_W] = lane_o_s[i].res;
                        ovf_d[i] = lane_o_s[i].ovf;
                        unf_d[i] = lane_o_s[i].unf;
                        exc_d[i] = lane_o_s[i].exc;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers: reset dominates, iCE low freezes everything including o_done.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 4'd0;
            cnt_q   <= '0;
            acc_q   <= '{default: '0};
            res_q   <= '0;
            ovf_q   <= '0;
            unf_q   <= '0;
            exc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (iCE) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            exc_q   <= exc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ALU_Output = res_q;
    assign Overflow   = ovf_q;
    assign Underflow  = unf_q;
    assign Exception  = exc_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed self-checking bench for vector_alu_seq (4 x 32-bit lanes); honours VALU_SATURATE_EN.
module tb_vector_alu_seq;

    localparam int NL = 4;
    localparam int LW = 32;
    localparam int VW = NL * LW;

`ifdef VALU_SATURATE_EN
    localparam logic [VW-1:0] ADD_EXP  = 128'h7FFFFFFF_00000004_00000003_00000002;
    localparam logic [VW-1:0] SUB_EXP  = 128'h80000000_FFFFFFFE_80000000_7FFFFFFF;
    localparam logic [VW-1:0] MUL1_EXP = 128'h00000000_FFFFFFCF_7FFFFFFF_FFFFFFF1;
    localparam logic [VW-1:0] MUL2_EXP = 128'h22222222_44444444_66666666_7FFFFFFF;
`else
    localparam logic [VW-1:0] ADD_EXP  = 128'h80000000_00000004_00000003_00000002;
    localparam logic [VW-1:0] SUB_EXP  = 128'h7FFFFFFF_FFFFFFFE_80000000_80000000;
    localparam logic [VW-1:0] MUL1_EXP = 128'h00000000_FFFFFFCF_540BE400_FFFFFFF1;
    localparam logic [VW-1:0] MUL2_EXP = 128'h22222222_44444444_66666666_88888888;
`endif
    localparam logic [VW-1:0] JUNK = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          iCE = 1'b1;
    logic          i_operand_sel = 1'b0;
    logic [VW-1:0] operand = '0;
    logic [3:0]    Operation = 4'd0;
    logic          i_start = 1'b0;
    logic [VW-1:0] ALU_Output;
    logic [NL-1:0] Overflow, Underflow, Exception;
    logic          o_busy, o_done;

    int n_checks = 0;
    int n_fail   = 0;

    vector_alu_seq #(.N_LANES(NL), .LANE_W(LW)) dut (
        .clk(clk), .i_rst(i_rst), .iCE(iCE), .i_operand_sel(i_operand_sel),
        .operand(operand), .Operation(Operation), .i_start(i_start),
        .ALU_Output(ALU_Output), .Overflow(Overflow), .Underflow(Underflow),
        .Exception(Exception), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [VW-1:0] v);
        i_operand_sel = sel;
        operand       = v;
        tick();
    endtask

    task automatic check_result(input string tag, input logic [VW-1:0] e_out,
                                input logic [NL-1:0] e_ovf, input logic [NL-1:0] e_unf,
                                input logic [NL-1:0] e_exc);
        check_eq({tag, "_out"}, ALU_Output, e_out);
        check_eq({tag, "_ovf"}, Overflow, e_ovf);
        check_eq({tag, "_unf"}, Underflow, e_unf);
        check_eq({tag, "_exc"}, Exception, e_exc);
    endtask

    // Issues op, optionally stalls iCE or drives ignored start/load traffic, and checks done latency.
    task automatic run_op(input logic [3:0] op, input string tag, input int exp_lat,
                          input int stall_at, input int stall_len, input bit junk);
        int n;
        n         = 0;
        Operation = op;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        Operation = 4'd0;
        check_eq({tag, "_busy"}, o_busy, 1'b1);
        while (n < 200) begin
            iCE = ((n >= stall_at) && (n < stall_at + stall_len)) ? 1'b0 : 1'b1;
            if (junk && (n < 6)) begin
                i_start       = (n < 3);
                i_operand_sel = n[0];
                operand       = JUNK;
            end else begin
                i_start = 1'b0;
            end
            tick();
            n++;
            if (o_done === 1'b1) break;
        end
        iCE     = 1'b1;
        i_start = 1'b0;
        check_eq({tag, "_lat"}, n, exp_lat);
    endtask

    initial begin
        int saw_done;
        tick();
        tick();
        i_rst = 1'b0;
        check_result("rst", '0, 4'b0000, 4'b0000, 4'b0000);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_done", o_done, 1'b0);

        load(1'b0, 128'h7FFFFFFF_00000003_00000002_00000001);
        load(1'b1, 128'h00000001_00000001_00000001_00000001);
        run_op(4'd0, "add", 1, 0, 0, 1'b0);
        check_result("add", ADD_EXP, 4'b1000, 4'b0000, 4'b0000);
        tick();
        check_eq("add_busy_end", o_busy, 1'b0);
        check_eq("add_done_end", o_done, 1'b0);
        check_eq("add_hold", ALU_Output, ADD_EXP);

        load(1'b0, 128'h80000000_00000005_FFFFFFFF_00000000);
        load(1'b1, 128'h00000001_00000007_7FFFFFFF_80000000);
        run_op(4'd1, "sub", 1, 0, 0, 1'b0);
        check_result("sub", SUB_EXP, 4'b0001, 4'b1000, 4'b0000);
        tick();
        run_op(4'd6, "min", 1, 0, 0, 1'b0);
        check_result("min", 128'h80000000_00000005_FFFFFFFF_80000000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        run_op(4'd7, "max", 1, 0, 0, 1'b0);
        check_result("max", 128'h00000001_00000007_7FFFFFFF_00000000, 4'b0000, 4'b0000, 4'b0000);
        tick();

        load(1'b0, 128'h00000000_00000007_000186A0_FFFFFFFD);
        load(1'b1, 128'h00000009_FFFFFFF9_000186A0_00000005);
        run_op(4'd2, "mul", 32, 0, 0, 1'b0);
        check_result("mul", MUL1_EXP, 4'b0010, 4'b0000, 4'b0000);
        tick();

        load(1'b0, 128'h80000000_80000000_80000000_80000000);
        load(1'b1, 128'h00000028_00000020_0000001F_00000001);
        run_op(4'd9, "sra", 1, 0, 0, 1'b0);
        check_result("sra", 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_C0000000, 4'b0000, 4'b0000, 4'b1100);
        tick();
        load(1'b0, 128'h00000001_00000001_00000001_00000001);
        run_op(4'd8, "sll", 1, 0, 0, 1'b0);
        check_result("sll", 128'h00000000_00000000_80000000_00000002, 4'b0000, 4'b0000, 4'b1100);
        tick();

        run_op(4'd13, "illegal", 1, 0, 0, 1'b0);
        check_result("illegal", '0, 4'b0000, 4'b0000, 4'b1111);
        iCE = 1'b0;
        tick();
        check_eq("ce_done_held", o_done, 1'b1);
        iCE = 1'b1;
        tick();
        check_eq("ce_done_clear", o_done, 1'b0);
        check_eq("ce_busy_clear", o_busy, 1'b0);

        load(1'b0, 128'h11111111_22222222_33333333_44444444);
        load(1'b1, 128'h00000002_00000002_00000002_00000002);
        run_op(4'd2, "hs_mul", 32, 0, 0, 1'b1);
        check_result("hs_mul", MUL2_EXP, 4'b0001, 4'b0000, 4'b0000);
        tick();
        run_op(4'd10, "pass", 1, 0, 0, 1'b0);
        check_result("pass", 128'h11111111_22222222_33333333_44444444, 4'b0000, 4'b0000, 4'b0000);
        tick();
        run_op(4'd5, "xor", 1, 0, 0, 1'b0);
        check_result("xor", 128'h11111113_22222220_33333331_44444446, 4'b0000, 4'b0000, 4'b0000);
        tick();
        run_op(4'd2, "stall_mul", 35, 10, 3, 1'b0);
        check_result("stall_mul", MUL2_EXP, 4'b0001, 4'b0000, 4'b0000);
        tick();

        Operation = 4'd2;
        i_start   = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (10) tick();
        i_rst = 1'b1;
        iCE   = 1'b0;
        tick();
        check_result("abort", '0, 4'b0000, 4'b0000, 4'b0000);
        check_eq("abort_busy", o_busy, 1'b0);
        check_eq("abort_done", o_done, 1'b0);
        i_rst    = 1'b0;
        iCE      = 1'b1;
        saw_done = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_done === 1'b1) saw_done = 1;
        end
        check_eq("abort_no_done", saw_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
